// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, register names and expander types
//
// Purpose: constants and types shared by the decoder, control unit and the
//          li pseudo-instruction expander.
// Ports:   none (package).
package mips_pkg;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_LAST  = 2'd2
  } li_state_t;

  typedef enum logic [1:0] {
    CLS_S16  = 2'd0,
    CLS_U16  = 2'd1,
    CLS_HI   = 2'd2,
    CLS_PAIR = 2'd3
  } imm_class_t;

  // I-type word: opcode | rs | rt | imm16
  function automatic logic [31:0] enc_itype(input logic [5:0]  op,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_classify.sv
// rtl/imm_classify.sv - combinational classifier for 32-bit li constants
//
// Purpose: decide the shortest I-type sequence able to rebuild in_imm.
// Ports:   in_imm    [31:0] constant to classify
//          imm_class [1:0]  S16 (addiu), U16 (ori), HI (lui) or PAIR (lui+ori)
module imm_classify
  import mips_pkg::*;
(
  input  logic [31:0] in_imm,
  output imm_class_t  imm_class
);

  logic is_s16;
  logic is_u16;
  logic is_hi;

  // addiu sign-extends, so bits 31:15 must all be copies of bit 15.
  assign is_s16 = (&in_imm[31:15]) || (~|in_imm[31:15]);
  assign is_u16 = ~|in_imm[31:16];
  assign is_hi  = ~|in_imm[15:0];

  // Priority order matters: 0 is S16, 0x0000_8000 is U16 not S16.
  always_comb begin
    imm_class = CLS_PAIR;
    if (is_s16)      imm_class = CLS_S16;
    else if (is_u16) imm_class = CLS_U16;
    else if (is_hi)  imm_class = CLS_HI;
  end

endmodule

// File: rtl/li_expander.sv
// rtl/li_expander.sv - expands li rt,imm32 into one or two MIPS I-type words
//
// Purpose: accepts a (rt, imm32) request and emits addiu / ori / lui or the
//          lui+ori pair, with valid/ready handshakes on both sides.
// Ports:   clk, reset          clock, synchronous active-high reset
//          in_valid/in_ready   request handshake
//          in_rt [4:0]         destination register
//          in_imm [31:0]       constant to load
//          out_valid/out_ready word handshake
//          out_instr [31:0]    encoded word (registered)
//          out_last            final word of the current expansion
// Params:  ENABLE_SHORT_FORMS  0 forces every request to lui+ori
module li_expander
  import mips_pkg::*;
#(
  parameter bit ENABLE_SHORT_FORMS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rt,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  li_state_t  state;
  imm_class_t raw_class;
  imm_class_t cls;
  logic [15:0] lo_q;
  logic [4:0]  rt_q;
  logic        accept;
  logic [31:0] first_word;
  logic        first_is_last;

  imm_classify u_classify (
    .in_imm    (in_imm),
    .imm_class (raw_class)
  );

  assign cls = ENABLE_SHORT_FORMS ? raw_class : CLS_PAIR;

  // A new request may enter while the final word drains, giving
  // back-to-back single-word expansions.
  assign in_ready = !reset &&
                    ((state == ST_IDLE) || ((state == ST_LAST) && out_ready));
  assign accept   = in_valid && in_ready;

  // First word of the accepted request; only reaches out_* through registers.
  always_comb begin
    first_word    = enc_itype(OP_LUI, REG_ZERO, in_rt, in_imm[31:16]);
    first_is_last = 1'b0;
    case (cls)
      CLS_S16: begin
        first_word    = enc_itype(OP_ADDIU, REG_ZERO, in_rt, in_imm[15:0]);
        first_is_last = 1'b1;
      end
      CLS_U16: begin
        first_word    = enc_itype(OP_ORI, REG_ZERO, in_rt, in_imm[15:0]);
        first_is_last = 1'b1;
      end
      CLS_HI: begin
        first_word    = enc_itype(OP_LUI, REG_ZERO, in_rt, in_imm[31:16]);
        first_is_last = 1'b1;
      end
      default: begin
        first_word    = enc_itype(OP_LUI, REG_ZERO, in_rt, in_imm[31:16]);
        first_is_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_instr <= 32'h0;
      lo_q      <= 16'h0;
      rt_q      <= 5'd0;
    end else begin
      if (accept) begin
        // Accept happens from IDLE or from a draining LAST; both land here.
        out_valid <= 1'b1;
        out_instr <= first_word;
        out_last  <= first_is_last;
        lo_q      <= in_imm[15:0];
        rt_q      <= in_rt;
        state     <= first_is_last ? ST_LAST : ST_FIRST;
      end else begin
        case (state)
          ST_FIRST: begin
            if (out_ready) begin
              out_instr <= enc_itype(OP_ORI, rt_q, rt_q, lo_q);
              out_last  <= 1'b1;
              state     <= ST_LAST;
            end
          end
          ST_LAST: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_li_expander.sv
// tb/tb_li_expander.sv - self-checking bench for li_expander and imm_classify
module tb_li_expander;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_valid2;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        out_ready;
  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_instr, out_instr2;
  logic        out_last,  out_last2;
  logic [31:0] cls_imm;
  imm_class_t  cls_out;

  int total;
  int bad;

  li_expander #(.ENABLE_SHORT_FORMS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last)
  );

  li_expander #(.ENABLE_SHORT_FORMS(1'b0)) dut_long (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_last(out_last2)
  );

  imm_classify u_cls (
    .in_imm(cls_imm),
    .imm_class(cls_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rt;
    logic [31:0] imm;
    bit          two;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          long_dut;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    imm_class_t  cls;
  } cvec_t;

  vec_t  vecs[13];
  cvec_t cvecs[8];

  // Drive one request with out_ready held high and check every word.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    in_rt = v.rt; in_imm = v.imm; out_ready = 1'b1;
    if (v.long_dut) in_valid2 = 1'b1; else in_valid = 1'b1;
    check("vec_in_ready", v.long_dut ? in_ready2 : in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0;
    check("vec_valid0", v.long_dut ? out_valid2 : out_valid, 1'b1);
    check("vec_word0",  v.long_dut ? out_instr2 : out_instr, v.w0);
    check("vec_last0",  v.long_dut ? out_last2  : out_last,  !v.two);
    if (v.two) begin
      @(negedge clk);
      check("vec_word1", v.long_dut ? out_instr2 : out_instr, v.w1);
      check("vec_last1", v.long_dut ? out_last2  : out_last,  1'b1);
    end
    @(negedge clk);
    check("vec_idle", v.long_dut ? out_valid2 : out_valid, 1'b0);
  endtask

  logic [31:0] b2b_exp[4];

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    in_rt = 5'd0; in_imm = 32'h0; out_ready = 1'b0; cls_imm = 32'h0;

    vecs[0]  = '{5'd8,  32'hFFFF_FFFB, 1'b0, 32'h2408_FFFB, 32'h0, 1'b0};
    vecs[1]  = '{5'd9,  32'h0000_8000, 1'b0, 32'h3409_8000, 32'h0, 1'b0};
    vecs[2]  = '{5'd10, 32'h1234_0000, 1'b0, 32'h3C0A_1234, 32'h0, 1'b0};
    vecs[3]  = '{5'd11, 32'h1234_5678, 1'b1, 32'h3C0B_1234, 32'h356B_5678, 1'b0};
    vecs[4]  = '{5'd0,  32'h0000_0000, 1'b0, 32'h2400_0000, 32'h0, 1'b0};
    vecs[5]  = '{5'd31, 32'h0000_7FFF, 1'b0, 32'h241F_7FFF, 32'h0, 1'b0};
    vecs[6]  = '{5'd5,  32'hFFFF_8000, 1'b0, 32'h2405_8000, 32'h0, 1'b0};
    vecs[7]  = '{5'd6,  32'h0000_FFFF, 1'b0, 32'h3406_FFFF, 32'h0, 1'b0};
    vecs[8]  = '{5'd7,  32'hFFFF_0000, 1'b0, 32'h3C07_FFFF, 32'h0, 1'b0};
    vecs[9]  = '{5'd12, 32'h8000_0001, 1'b1, 32'h3C0C_8000, 32'h358C_0001, 1'b0};
    vecs[10] = '{5'd1,  32'h0001_0000, 1'b0, 32'h3C01_0001, 32'h0, 1'b0};
    vecs[11] = '{5'd3,  32'h0000_0005, 1'b1, 32'h3C03_0000, 32'h3463_0005, 1'b1};
    vecs[12] = '{5'd2,  32'h0000_0000, 1'b1, 32'h3C02_0000, 32'h3442_0000, 1'b1};

    cvecs[0] = '{32'h0000_0000, CLS_S16};
    cvecs[1] = '{32'hFFFF_FFFF, CLS_S16};
    cvecs[2] = '{32'h0000_8000, CLS_U16};
    cvecs[3] = '{32'h0000_FFFF, CLS_U16};
    cvecs[4] = '{32'h0001_0000, CLS_HI};
    cvecs[5] = '{32'h8000_0000, CLS_HI};
    cvecs[6] = '{32'h0001_8000, CLS_PAIR};
    cvecs[7] = '{32'hFFFF_7FFF, CLS_PAIR};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last",  out_last,  1'b0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_valid_long", out_valid2, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Classifier unit vectors
    for (int i = 0; i < 8; i++) begin
      cls_imm = cvecs[i].imm;
      #1;
      check("classify", 32'(cls_out), 32'(cvecs[i].cls));
    end

    // Table vectors
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // PAIR with out_ready stalled for 3 cycles
    @(negedge clk);
    in_rt = 5'd11; in_imm = 32'h1234_5678; out_ready = 1'b0; in_valid = 1'b1;
    check("stall_accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_word",  out_instr, 32'h3C0B_1234);
      check("stall_last",  out_last,  1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    check("stall_word_after", out_instr, 32'h3C0B_1234);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_ori", out_instr, 32'h356B_5678);
    check("stall_ori_last", out_last, 1'b1);
    check("stall_ori_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check("stall_idle", out_valid, 1'b0);

    // Back-to-back S16 requests, one word per cycle
    b2b_exp[0] = 32'h2401_0000; b2b_exp[1] = 32'h2402_0001;
    b2b_exp[2] = 32'h2403_0002; b2b_exp[3] = 32'h2404_0003;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_word",  out_instr, b2b_exp[k-1]);
        check("b2b_last",  out_last,  1'b1);
      end
      in_valid = 1'b1; in_rt = 5'(k + 1); in_imm = 32'(k);
      #1;
      check("b2b_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_word_last", out_instr, b2b_exp[3]);
    check("b2b_valid_last", out_valid, 1'b1);
    @(negedge clk);
    check("b2b_idle", out_valid, 1'b0);

    // Reset while in FIRST drops the pending ori
    out_ready = 1'b0;
    in_valid = 1'b1; in_rt = 5'd11; in_imm = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_first_valid", out_valid, 1'b1);
    check("abort_first_word", out_instr, 32'h3C0B_1234);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", out_valid, 1'b0);
    check("abort_instr", out_instr, 32'h0);
    check("abort_in_ready", in_ready, 1'b0);
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_ori", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
